// File: rtl/a2d_pkg.sv
// Shared definitions for the A2D round-robin scan scheduler.
// Contents: the FSM state type, the ADC128S channel numbers that are
// scanned, the slot-to-channel lookup and the SPI command word builder.
package a2d_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CMD,
    WAIT1,
    GAP,
    READ,
    WAIT2,
    LATCH,
    ABORT
  } state_t;

  localparam logic [2:0] CH_LFT   = 3'd0;
  localparam logic [2:0] CH_RGHT  = 3'd4;
  localparam logic [2:0] CH_STEER = 3'd5;
  localparam logic [2:0] CH_BATT  = 3'd6;

  // Scan order: left load cell, right load cell, steering pot, battery.
  function automatic logic [2:0] slot2chan(input logic [1:0] slot);
    logic [2:0] ch;
    case (slot)
      2'd0:    ch = CH_LFT;
      2'd1:    ch = CH_RGHT;
      2'd2:    ch = CH_STEER;
      default: ch = CH_BATT;
    endcase
    return ch;
  endfunction

  // ADC128S control word: channel address sits in bits [13:11].
  function automatic logic [15:0] cmd_word(input logic [2:0] chan);
    return {2'b00, chan, 11'h000};
  endfunction

endpackage

// File: rtl/a2d_scan_sched.sv
// a2d_scan_sched: sequences the ADC128S through the SPI master, one channel
// every SCAN_PERIOD idle cycles, and holds the latest result per channel.
// Each reading is a channel-select transaction followed by a dummy read that
// returns that channel's conversion.
//
// Ports:
//   clk        system clock
//   rst_n      synchronous active-low reset
//   en         scanning enable (period timer holds at 0 while low)
//   clr_err    clears the sticky timeout flag
//   done       SPI master transaction complete (1-cycle pulse)
//   rd_data    SPI master received word
//   wrt        1-cycle pulse launching an SPI transaction
//   wt_data    word for the SPI master to send
//   lft_ld, rght_ld, steer_pot, batt   latest 12-bit results
//   vld        one-hot pulse, bit i = slot i just updated
//   scan_cmplt pulse coincident with vld[3]
//   err        sticky timeout flag
module a2d_scan_sched
  import a2d_pkg::*;
#(
  parameter int SCAN_PERIOD = 4096,
  parameter int TIMEOUT     = 1024
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic        clr_err,
  input  logic        done,
  input  logic [15:0] rd_data,
  output logic        wrt,
  output logic [15:0] wt_data,
  output logic [11:0] lft_ld,
  output logic [11:0] rght_ld,
  output logic [11:0] steer_pot,
  output logic [11:0] batt,
  output logic [3:0]  vld,
  output logic        scan_cmplt,
  output logic        err
);

  localparam int PW = (SCAN_PERIOD > 1) ? $clog2(SCAN_PERIOD) : 1;
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  state_t        state_q, state_d;
  logic [1:0]    slot_q, slot_d;
  logic [PW-1:0] ptmr_q, ptmr_d;
  logic [TW-1:0] ttmr_q, ttmr_d;
  logic [11:0]   rdat_q, rdat_d;
  logic [11:0]   lft_q, rght_q, steer_q, batt_q;
  logic [3:0]    vld_q;
  logic          cmplt_q;
  logic          err_q;
  logic          latch_en;
  logic          abort_set;

  // The converter returns 12-bit results; the upper nibble carries no data.
  logic unused_rd_hi;
  assign unused_rd_hi = ^rd_data[15:12];

  always_comb begin
    state_d   = state_q;
    slot_d    = slot_q;
    ptmr_d    = ptmr_q;
    ttmr_d    = ttmr_q;
    rdat_d    = rdat_q;
    wrt       = 1'b0;
    wt_data   = 16'h0000;
    latch_en  = 1'b0;
    abort_set = 1'b0;
    case (state_q)
      IDLE: begin
        if (!en) begin
          ptmr_d = '0;
        end else if (ptmr_q == PW'(SCAN_PERIOD - 1)) begin
          ptmr_d  = '0;
          state_d = CMD;
        end else begin
          ptmr_d = ptmr_q + PW'(1);
        end
      end
      CMD: begin
        wrt     = 1'b1;
        wt_data = cmd_word(slot2chan(slot_q));
        ttmr_d  = '0;
        state_d = WAIT1;
      end
      WAIT1: begin
        // done is tested first so a completion on the terminal count wins.
        if (done) begin
          state_d = GAP;
        end else if (ttmr_q == TW'(TIMEOUT - 1)) begin
          state_d   = ABORT;
          abort_set = 1'b1;
        end else begin
          ttmr_d = ttmr_q + TW'(1);
        end
      end
      GAP: state_d = READ;
      READ: begin
        // Dummy read re-sends the same channel; the reply is this channel.
        wrt     = 1'b1;
        wt_data = cmd_word(slot2chan(slot_q));
        ttmr_d  = '0;
        state_d = WAIT2;
      end
      WAIT2: begin
        if (done) begin
          rdat_d  = rd_data[11:0];
          state_d = LATCH;
        end else if (ttmr_q == TW'(TIMEOUT - 1)) begin
          state_d   = ABORT;
          abort_set = 1'b1;
        end else begin
          ttmr_d = ttmr_q + TW'(1);
        end
      end
      LATCH: begin
        latch_en = 1'b1;
        slot_d   = slot_q + 2'd1;
        state_d  = IDLE;
      end
      ABORT: begin
        // err is raised on the edge entering this state; only the slot moves on.
        slot_d  = slot_q + 2'd1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      slot_q  <= 2'd0;
      ptmr_q  <= '0;
      ttmr_q  <= '0;
      rdat_q  <= 12'h000;
      lft_q   <= 12'h000;
      rght_q  <= 12'h000;
      steer_q <= 12'h000;
      batt_q  <= 12'h000;
      vld_q   <= 4'b0000;
      cmplt_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      slot_q  <= slot_d;
      ptmr_q  <= ptmr_d;
      ttmr_q  <= ttmr_d;
      rdat_q  <= rdat_d;
      vld_q   <= latch_en ? (4'b0001 << slot_q) : 4'b0000;
      cmplt_q <= latch_en && (slot_q == 2'd3);
      if (latch_en) begin
        case (slot_q)
          2'd0:    lft_q   <= rdat_q;
          2'd1:    rght_q  <= rdat_q;
          2'd2:    steer_q <= rdat_q;
          default: batt_q  <= rdat_q;
        endcase
      end
      // A new abort outranks a simultaneous clear request.
      if (abort_set) begin
        err_q <= 1'b1;
      end else if (clr_err) begin
        err_q <= 1'b0;
      end
    end
  end

  assign lft_ld     = lft_q;
  assign rght_ld    = rght_q;
  assign steer_pot  = steer_q;
  assign batt       = batt_q;
  assign vld        = vld_q;
  assign scan_cmplt = cmplt_q;
  assign err        = err_q;

endmodule

// File: tb/tb_a2d_scan_sched.sv
// Self-checking bench for a2d_scan_sched with a behavioural ADC128S/SPI model.
module tb_a2d_scan_sched;

  localparam int SP = 64;
  localparam int TO = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic        clr_err = 1'b0;
  logic        adc_done = 1'b0;
  logic        stray_done = 1'b0;
  logic        done;
  logic [15:0] rd_data = 16'h0000;
  logic        wrt;
  logic [15:0] wt_data;
  logic [11:0] lft_ld, rght_ld, steer_pot, batt;
  logic [3:0]  vld;
  logic        scan_cmplt;
  logic        err;

  assign done = adc_done | stray_done;

  a2d_scan_sched #(.SCAN_PERIOD(SP), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .clr_err(clr_err), .done(done),
    .rd_data(rd_data), .wrt(wrt), .wt_data(wt_data), .lft_ld(lft_ld),
    .rght_ld(rght_ld), .steer_pot(steer_pot), .batt(batt), .vld(vld),
    .scan_cmplt(scan_cmplt), .err(err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail = 0;
  int cyc = 0;
  int vld_cnt = 0;
  int cmplt_cnt = 0;
  logic [15:0] sb_q[$];
  logic adc_mute = 1'b0;
  int adc_lat2 = 5;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h expected=%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [11:0] adc_val(input logic [2:0] ch);
    case (ch)
      3'd0:    return 12'h200;
      3'd4:    return 12'h210;
      3'd5:    return 12'h800;
      3'd6:    return 12'hFFF;
      default: return 12'h000;
    endcase
  endfunction

  function automatic logic [3:0] ch_onehot(input logic [2:0] ch);
    case (ch)
      3'd0:    return 4'b0001;
      3'd4:    return 4'b0010;
      3'd5:    return 4'b0100;
      3'd6:    return 4'b1000;
      default: return 4'b0000;
    endcase
  endfunction

  function automatic logic [15:0] slot_cmd(input int s);
    case (s)
      0:       return 16'h0000;
      1:       return 16'h2000;
      2:       return 16'h2800;
      default: return 16'h3000;
    endcase
  endfunction

  function automatic logic [11:0] result_of(input logic [3:0] v);
    case (v)
      4'b0001: return lft_ld;
      4'b0010: return rght_ld;
      4'b0100: return steer_pot;
      4'b1000: return batt;
      default: return 12'h000;
    endcase
  endfunction

  // ADC128S + SPI master model: each transaction returns the conversion of
  // the channel addressed by the previous transaction.
  initial begin
    logic [2:0]  prev_chan;
    logic [2:0]  chan;
    logic [11:0] resp;
    logic        aphase;
    int          lat;
    prev_chan = 3'd0;
    aphase = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        aphase = 1'b0;
      end else if (wrt) begin
        chan = wt_data[13:11];
        resp = adc_val(prev_chan);
        prev_chan = chan;
        if (aphase && adc_mute) begin
          aphase = 1'b0;
        end else begin
          lat = aphase ? adc_lat2 : 5;
          repeat (lat) @(posedge clk);
          #1;
          rd_data = {4'hA, resp};
          adc_done = 1'b1;
          if (aphase) sb_q.push_back({ch_onehot(chan), resp});
          @(posedge clk);
          #1 adc_done = 1'b0;
          aphase = ~aphase;
        end
      end
    end
  end

  // Output monitor: command words, handshake timing and result scoreboard.
  initial begin
    int m_slot, pending, done1_cyc, latch_cyc;
    logic m_phase, prev_wrt;
    logic [15:0] e;
    m_slot = 0; pending = 0; done1_cyc = 0; latch_cyc = 0;
    m_phase = 1'b0; prev_wrt = 1'b0;
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst_n) begin
        m_slot = 0; pending = 0; m_phase = 1'b0; prev_wrt = 1'b0;
      end else begin
        if (wrt) begin
          chk("wrt_1cyc", 32'(prev_wrt), 0);
          chk("wt_data", 32'(wt_data), 32'(slot_cmd(m_slot)));
          if (m_phase) begin
            chk("gap", cyc, done1_cyc + 2);
            m_slot = (m_slot + 1) % 4;
            pending = 2;
          end else begin
            pending = 1;
          end
          m_phase = ~m_phase;
        end
        if (done && pending == 1) begin
          done1_cyc = cyc;
          pending = 0;
        end else if (done && pending == 2) begin
          latch_cyc = cyc + 2;
          pending = 0;
        end
        if (vld != 4'b0000) begin
          vld_cnt++;
          if (scan_cmplt) cmplt_cnt++;
          if (sb_q.size() == 0) begin
            chk("sb_empty", 32'(vld), 0);
          end else begin
            e = sb_q.pop_front();
            chk("vld", 32'(vld), 32'(e[15:12]));
            chk("lat", cyc, latch_cyc);
            chk("cmplt", 32'(scan_cmplt), 32'(e[15]));
            chk("data", 32'(result_of(vld)), 32'(e[11:0]));
          end
        end else if (scan_cmplt) begin
          chk("cmplt_stray", 32'(scan_cmplt), 0);
        end
        prev_wrt = wrt;
      end
    end
  end

  task automatic wait_vld(input string tag, input int target, input int budget);
    int n = 0;
    while (vld_cnt < target && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (vld_cnt < target) chk(tag, vld_cnt, target);
  endtask

  task automatic wait_wrt(input string tag, input int budget);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!wrt && n < budget);
    if (!wrt) chk(tag, 32'(wrt), 1);
  endtask

  // Called at a negedge: raise en and count cycles to the launch.
  task automatic measure_launch(input string tag, input logic [15:0] word);
    int k = 0;
    en = 1'b1;
    do begin
      @(negedge clk);
      k++;
    end while (!wrt && k < SP + 32);
    chk({tag, "_gap"}, k, SP);
    chk({tag, "_word"}, 32'(wt_data), 32'(word));
  endtask

  task automatic count_quiet(input string tag, input int ncyc);
    int cnt = 0;
    repeat (ncyc) begin
      @(negedge clk);
      if (wrt) cnt++;
    end
    chk(tag, cnt, 0);
  endtask

  task automatic pulse_reset();
    @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_wrt"}, 32'(wrt), 0);
    chk({tag, "_wt"}, 32'(wt_data), 0);
    chk({tag, "_lft"}, 32'(lft_ld), 0);
    chk({tag, "_rght"}, 32'(rght_ld), 0);
    chk({tag, "_steer"}, 32'(steer_pot), 0);
    chk({tag, "_batt"}, 32'(batt), 0);
    chk({tag, "_vld"}, 32'(vld), 0);
    chk({tag, "_cmplt"}, 32'(scan_cmplt), 0);
    chk({tag, "_err"}, 32'(err), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired at t=%0t", $time);
    $fatal(1);
  end

  initial begin
    // Reset state
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check_zero("rst");

    // Basic scan of all four slots
    measure_launch("first", 16'h0000);
    wait_vld("scan_tmo", 4, 2000);
    @(negedge clk);
    chk("scan_lft", 32'(lft_ld), 32'h200);
    chk("scan_rght", 32'(rght_ld), 32'h210);
    chk("scan_steer", 32'(steer_pot), 32'h800);
    chk("scan_batt", 32'(batt), 32'hFFF);
    chk("scan_cmplt_cnt", cmplt_cnt, 1);

    // Timeout in slot2 WAIT2, with clr_err held across the abort cycle
    wait_vld("to_pre", 6, 2000);
    adc_mute = 1'b1;
    wait_wrt("to_cmd", 400);
    wait_wrt("to_read", 400);
    repeat (15) @(negedge clk);
    clr_err = 1'b1;
    @(negedge clk);
    chk("err_pre", 32'(err), 0);
    @(negedge clk);
    chk("err_set", 32'(err), 1);
    clr_err = 1'b0;
    adc_mute = 1'b0;
    wait_wrt("to_next", 400);
    chk("to_next_word", 32'(wt_data), 32'h3000);
    chk("to_steer_kept", 32'(steer_pot), 32'h800);
    @(negedge clk);
    chk("err_sticky", 32'(err), 1);
    clr_err = 1'b1;
    @(negedge clk);
    clr_err = 1'b0;
    chk("err_clr", 32'(err), 0);

    // Enable dropped during WAIT1 of slot1
    wait_vld("gate_pre", 8, 2000);
    wait_wrt("gate_cmd", 400);
    chk("gate_cmd_word", 32'(wt_data), 32'h2000);
    @(negedge clk);
    en = 1'b0;
    wait_vld("gate_finish", 9, 400);
    chk("gate_rght", 32'(rght_ld), 32'h210);
    count_quiet("gate_quiet", 10 * SP);
    measure_launch("reen", 16'h2800);

    // Reset glitch between edges must be ignored
    wait_vld("glitch_pre", 10, 400);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("glitch_lft", 32'(lft_ld), 32'h200);
    chk("glitch_batt", 32'(batt), 32'hFFF);

    // Reset in the middle of slot3 WAIT2
    adc_mute = 1'b1;
    wait_wrt("mrst_cmd", 400);
    chk("mrst_cmd_word", 32'(wt_data), 32'h3000);
    wait_wrt("mrst_read", 400);
    repeat (3) @(negedge clk);
    en = 1'b0;
    pulse_reset();
    check_zero("mrst");
    adc_mute = 1'b0;

    // Stray done in IDLE, then done on the timeout terminal count
    stray_done = 1'b1;
    @(negedge clk);
    stray_done = 1'b0;
    count_quiet("stray_quiet", 10);
    adc_lat2 = TO;
    measure_launch("post_rst", 16'h0000);
    wait_vld("edge_done", vld_cnt + 1, 400);
    @(negedge clk);
    chk("edge_err", 32'(err), 0);
    chk("edge_lft", 32'(lft_ld), 32'h200);

    en = 1'b0;
    repeat (5) @(negedge clk);
    chk("sb_drained", sb_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
